parity_engine: RTL and testbench
================================

// Module: parity_engine
// PURPOSE
//   Parametrised parity unit shared by UART TX and RX. Parallel path: registered
//   parity generation for a TX frame word, in one of four modes. Serial path:
//   bit-serial parity accumulation and check of an RX frame, with error flag.
//   Sits between the frame FSM / serializer and the TX mux or RX deserializer.
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame (1..16); serial bit counter is $clog2(DATA_WIDTH+1) wide
// PORTS
//   CLK           in   1           system clock, rising edge
//   RST           in   1           reset, asynchronous, active-low
//   par_en        in   1           1 = parity enabled; 0 = no parity bit in frame
//   par_typ       in   2           00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
//   data_valid    in   1           1-cycle strobe: P_DATA holds a new TX word
//   P_DATA        in   DATA_WIDTH  TX word
//   par_bit       out  1           registered TX parity bit
//   par_bit_vld   out  1           1-cycle pulse, par_bit updated
//   ser_start     in   1           1-cycle strobe: new RX frame begins (after start bit)
//   ser_stb       in   1           sample strobe: ser_bit is valid this cycle
//   ser_bit       in   1           RX serial bit, data LSB first, then parity bit
//   chk_done      out  1           1-cycle pulse, RX check complete
//   par_err       out  1           parity mismatch of last RX frame; held until next ser_start
// BEHAVIOUR
//   Reset: par_bit=0, par_bit_vld=0, chk_done=0, par_err=0, FSM=IDLE, counter=0, acc=0.
//   Parity function f(d,typ): even ^d; odd ~^d; mark 1; space 0. f=0 when par_en=0.
//   Parallel path: on data_valid, par_bit <= f(P_DATA,par_typ) at next edge
//     (latency 1 clk); par_bit_vld pulses that same cycle. par_bit holds otherwise.
//     Back-to-back data_valid: each cycle updates, par_bit_vld stays high.
//   Serial FSM, states IDLE, DATA, PAR:
//     IDLE: ser_start -> DATA; clear acc, counter, par_err; latch par_en/par_typ.
//     DATA: each ser_stb: acc ^= ser_bit, counter++. On DATA_WIDTH-th strobe:
//       latched par_en=1 -> PAR; par_en=0 -> IDLE, chk_done pulse, par_err=0.
//     PAR: on ser_stb: expected = f(acc) using latched mode (even: acc, odd: ~acc,
//       mark 1, space 0); par_err <= (ser_bit != expected); chk_done pulse; -> IDLE.
//   ser_stb without ser_start in IDLE: ignored.
//   ser_start in DATA or PAR: abort current frame, no chk_done, restart as from IDLE.
//   ser_start and ser_stb same cycle: start wins; that strobe is not counted.
//   Mode inputs changing mid-frame: no effect on the frame in progress.
//   Parallel and serial paths are independent; simultaneous activity is legal.
//   RST asserted mid-operation: all state and outputs return to reset values at once.
// STRUCTURE
//   Package parity_pkg: par_typ encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE),
//     FSM state encodings (ST_IDLE, ST_DATA, ST_PAR).
//   Sub-module parity_func: combinational f(d, par_en, par_typ) over DATA_WIDTH,
//     used by parallel path; serial path reuses the same mode decode on 1-bit acc.
//   Top holds parallel output register and serial FSM + counter + accumulator.
// TESTING
//   1. par_en=1, typ=00, P_DATA=8'hA5 strobe -> next cycle par_bit=0, par_bit_vld=1;
//      typ=01 same data -> par_bit=1; typ=10 -> 1; typ=11 -> 0; par_en=0 -> 0.
//   2. Serial even, bits of 8'h07 LSB first then parity 1 -> chk_done pulse, par_err=0;
//      repeat with parity 0 -> par_err=1, held until next ser_start clears it.
//   3. Serial odd, data 8'h00, parity 1 -> par_err=0; par_en=0 frame of 8 bits ->
//      chk_done after 8th strobe, FSM in IDLE, 9th strobe ignored.
//   4. ser_start after 4 data strobes -> no chk_done; following full frame 8'hFF
//      even parity 0 checks correctly (par_err=0).
//   5. Change par_typ even->odd during DATA of 8'h01 with parity 1 -> par_err=0
//      (latched even mode used).
//   6. RST low during PAR state with par_err=1 -> all outputs 0 asynchronously;
//      DATA_WIDTH=5 build: data 5'h1F even, parity 1 -> par_err=0.

Source files
------------

// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
//   Shared definitions for the UART parity engine:
//     - par_typ_t : parity mode encodings (even / odd / mark / space)
//     - state_t   : serial checker FSM states
//     - apply_mode: maps a reduction-XOR of the data onto the parity bit for a
//                   given mode. The parallel generator and the serial checker
//                   both go through this one decode, so they cannot disagree.
// -----------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PAR  = 2'b10
  } state_t;

  // red is the XOR of all data bits (1 when the data holds an odd number of
  // ones). Even parity appends red so the total count of ones becomes even;
  // odd parity appends its complement. With parity disabled the bit is 0.
  function automatic logic apply_mode(input logic     red,
                                      input logic     en,
                                      input par_typ_t typ);
    logic p;
    p = 1'b0;
    if (en) begin
      case (typ)
        PAR_EVEN:  p = red;
        PAR_ODD:   p = ~red;
        PAR_MARK:  p = 1'b1;
        PAR_SPACE: p = 1'b0;
        default:   p = 1'b0;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/parity_func.sv
// -----------------------------------------------------------------------------
// parity_func
//   Combinational parity function f(d, par_en, par_typ) over a DATA_WIDTH word.
//
// Ports
//   d        in   DATA_WIDTH  data word
//   par_en   in   1           parity enabled (0 forces par to 0)
//   par_typ  in   par_typ_t   parity mode
//   par      out  1           parity bit for the word
// -----------------------------------------------------------------------------
module parity_func
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  par_en,
  input  par_typ_t              par_typ,
  output logic                  par
);

  assign par = apply_mode(^d, par_en, par_typ);

endmodule

// File: rtl/parity_engine.sv
// -----------------------------------------------------------------------------
// parity_engine
//   Parity unit shared by UART TX and RX.
//   Parallel path: registered parity bit for a TX word, one cycle after
//   data_valid, with a one-cycle valid pulse.
//   Serial path: bit-serial accumulation of an RX frame (data LSB first, then
//   an optional parity bit) and comparison against the expected parity.
//
// Parameters
//   DATA_WIDTH   data bits per frame (1..16)
//
// Ports
//   CLK          in   1           system clock, rising edge
//   RST          in   1           asynchronous active-low reset
//   par_en       in   1           parity bit present in frame
//   par_typ      in   2           00 even, 01 odd, 10 mark, 11 space
//   data_valid   in   1           TX word strobe
//   P_DATA       in   DATA_WIDTH  TX word
//   par_bit      out  1           registered TX parity bit
//   par_bit_vld  out  1           par_bit updated this cycle
//   ser_start    in   1           new RX frame begins
//   ser_stb      in   1           ser_bit valid this cycle
//   ser_bit      in   1           RX serial bit
//   chk_done     out  1           RX check complete (1-cycle pulse)
//   par_err      out  1           parity mismatch of last RX frame
// -----------------------------------------------------------------------------
module parity_engine
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  par_en,
  input  logic [1:0]            par_typ,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  par_bit,
  output logic                  par_bit_vld,
  input  logic                  ser_start,
  input  logic                  ser_stb,
  input  logic                  ser_bit,
  output logic                  chk_done,
  output logic                  par_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  // Counter value seen while the final data bit is being strobed in.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Parallel path
  // ---------------------------------------------------------------------------
  logic par_calc;

  parity_func #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_func (
    .d      (P_DATA),
    .par_en (par_en),
    .par_typ(par_typ_t'(par_typ)),
    .par    (par_calc)
  );

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values, independent of the order of always blocks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit     <= 1'b0;
      par_bit_vld <= 1'b0;
    end else begin
      par_bit_vld <= data_valid;
      if (data_valid) begin
        par_bit <= par_calc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serial path: state register plus next-state/output logic
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             en_q, en_d;
  par_typ_t         typ_q, typ_d;
  logic             done_d;
  logic             err_d;
  logic             exp_bit;

  // Expected parity bit for the frame, decoded with the mode latched at start.
  // Only consulted in ST_PAR, which is entered only with parity enabled.
  assign exp_bit = apply_mode(acc_q, 1'b1, typ_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      en_q     <= 1'b0;
      typ_q    <= PAR_EVEN;
      chk_done <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      en_q     <= en_d;
      typ_q    <= typ_d;
      chk_done <= done_d;
      par_err  <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    en_d    = en_q;
    typ_d   = typ_q;
    done_d  = 1'b0;
    err_d   = par_err;

    if (ser_start) begin
      // Start has priority in every state: it aborts any frame in progress
      // without a chk_done, and a same-cycle strobe is not counted.
      state_d = ST_DATA;
      cnt_d   = '0;
      acc_d   = 1'b0;
      err_d   = 1'b0;
      en_d    = par_en;
      typ_d   = par_typ_t'(par_typ);
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Strobes outside a frame are ignored.
        end

        ST_DATA: begin
          if (ser_stb) begin
            acc_d = acc_q ^ ser_bit;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              if (en_q) begin
                state_d = ST_PAR;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b0;
              end
            end
          end
        end

        ST_PAR: begin
          if (ser_stb) begin
            err_d   = (ser_bit != exp_bit);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_engine.sv
// -----------------------------------------------------------------------------
// tb_parity_engine
//   Self-checking bench for parity_engine. An 8-bit instance is compared every
//   cycle against a frame-level model (word assembly + popcount); directed
//   vectors also carry hand-computed literal expectations. A 5-bit instance
//   covers the narrow-width build.
// -----------------------------------------------------------------------------
module tb_parity_engine;

  localparam int W  = 8;
  localparam int W5 = 5;

  localparam logic [1:0] T_EVEN  = 2'b00;
  localparam logic [1:0] T_ODD   = 2'b01;
  localparam logic [1:0] T_MARK  = 2'b10;
  localparam logic [1:0] T_SPACE = 2'b11;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  // Shared mode inputs
  logic       par_en  = 1'b0;
  logic [1:0] par_typ = 2'b00;

  // 8-bit instance
  logic         data_valid = 1'b0;
  logic [W-1:0] p_data     = '0;
  logic         ser_start  = 1'b0;
  logic         ser_stb    = 1'b0;
  logic         ser_bit    = 1'b0;
  logic         par_bit, par_bit_vld, chk_done, par_err;

  // 5-bit instance
  logic          dv5     = 1'b0;
  logic [W5-1:0] p_data5 = '0;
  logic          s5_start = 1'b0;
  logic          s5_stb   = 1'b0;
  logic          s5_bit   = 1'b0;
  logic          par_bit5, par_bit_vld5, chk_done5, par_err5;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  parity_engine #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .data_valid (data_valid),
    .P_DATA     (p_data),
    .par_bit    (par_bit),
    .par_bit_vld(par_bit_vld),
    .ser_start  (ser_start),
    .ser_stb    (ser_stb),
    .ser_bit    (ser_bit),
    .chk_done   (chk_done),
    .par_err    (par_err)
  );

  parity_engine #(.DATA_WIDTH(W5)) dut5 (
    .CLK        (CLK),
    .RST        (RST),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .data_valid (dv5),
    .P_DATA     (p_data5),
    .par_bit    (par_bit5),
    .par_bit_vld(par_bit_vld5),
    .ser_start  (s5_start),
    .ser_stb    (s5_stb),
    .ser_bit    (s5_bit),
    .chk_done   (chk_done5),
    .par_err    (par_err5)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (8-bit instance), frame level
  // ---------------------------------------------------------------------------
  function automatic logic ref_par(input logic [15:0] w, input logic en,
                                   input logic [1:0] typ);
    int ones;
    ones = $countones(w);
    if (!en) return 1'b0;
    case (typ)
      T_EVEN:  return (ones % 2) == 1;   // make total count even
      T_ODD:   return (ones % 2) == 0;   // make total count odd
      T_MARK:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic        m_par_bit, m_vld, m_done, m_err;
  logic        m_busy;
  int          m_n;
  logic [15:0] m_word;
  logic        m_en;
  logic [1:0]  m_typ;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_par_bit = 1'b0; m_vld = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_busy = 1'b0; m_n = 0; m_word = '0; m_en = 1'b0; m_typ = 2'b00;
    end else begin
      m_vld = data_valid;
      if (data_valid) m_par_bit = ref_par(16'(p_data), par_en, par_typ);
      m_done = 1'b0;
      if (ser_start) begin
        m_busy = 1'b1; m_n = 0; m_word = '0; m_err = 1'b0;
        m_en = par_en; m_typ = par_typ;
      end else if (m_busy && ser_stb) begin
        if (m_n < W) begin
          m_word[m_n] = ser_bit;
          m_n++;
          if (m_n == W && !m_en) begin
            m_busy = 1'b0; m_done = 1'b1; m_err = 1'b0;
          end
        end else begin
          m_err  = (ser_bit != ref_par(m_word, 1'b1, m_typ));
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  // Compare process: outputs are registered, sampled mid-cycle.
  always @(negedge CLK) begin
    check("cyc_par_bit", par_bit, m_par_bit);
    check("cyc_par_bit_vld", par_bit_vld, m_vld);
    check("cyc_chk_done", chk_done, m_done);
    check("cyc_par_err", par_err, m_err);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic pstrobe(input logic [W-1:0] d, input logic en, input logic [1:0] typ);
    data_valid = 1'b1; p_data = d; par_en = en; par_typ = typ;
    @(negedge CLK);
    data_valid = 1'b0;
  endtask

  task automatic sstart(input logic en, input logic [1:0] typ);
    ser_start = 1'b1; par_en = en; par_typ = typ;
    @(negedge CLK);
    ser_start = 1'b0;
  endtask

  task automatic sbit(input logic b);
    ser_stb = 1'b1; ser_bit = b;
    @(negedge CLK);
    ser_stb = 1'b0; ser_bit = 1'b0;
  endtask

  task automatic do_frame(input string name, input logic [W-1:0] d, input logic en,
                          input logic [1:0] typ, input logic p, input logic exp_err);
    sstart(en, typ);
    for (int i = 0; i < W; i++) sbit(d[i]);
    if (en) sbit(p);
    check({name, "_done"}, chk_done, 1'b1);
    check({name, "_err"}, par_err, exp_err);
  endtask

  task automatic frame5(input string name, input logic [W5-1:0] d, input logic p,
                        input logic exp_err);
    par_en = 1'b1; par_typ = T_EVEN;
    s5_start = 1'b1;
    @(negedge CLK);
    s5_start = 1'b0;
    for (int i = 0; i < W5; i++) begin
      s5_stb = 1'b1; s5_bit = d[i];
      @(negedge CLK);
    end
    s5_bit = p;
    @(negedge CLK);
    s5_stb = 1'b0; s5_bit = 1'b0;
    check({name, "_done"}, chk_done5, 1'b1);
    check({name, "_err"}, par_err5, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (2) @(negedge CLK);
    check("rst_par_bit", par_bit, 1'b0);
    check("rst_vld", par_bit_vld, 1'b0);
    check("rst_done", chk_done, 1'b0);
    check("rst_err", par_err, 1'b0);
    RST = 1'b1;
    @(negedge CLK);

    // 1. Parallel path, A5 has four ones; back-to-back strobes
    pstrobe(8'hA5, 1'b1, T_EVEN);
    check("p_even", par_bit, 1'b0);
    check("p_even_vld", par_bit_vld, 1'b1);
    pstrobe(8'hA5, 1'b1, T_ODD);
    check("p_odd", par_bit, 1'b1);
    check("p_b2b_vld", par_bit_vld, 1'b1);
    pstrobe(8'hA5, 1'b1, T_MARK);
    check("p_mark", par_bit, 1'b1);
    pstrobe(8'hA5, 1'b1, T_SPACE);
    check("p_space", par_bit, 1'b0);
    pstrobe(8'hA5, 1'b0, T_ODD);
    check("p_dis", par_bit, 1'b0);
    pstrobe(8'h07, 1'b1, T_EVEN);
    check("p_even07", par_bit, 1'b1);
    @(negedge CLK);
    check("p_hold", par_bit, 1'b1);
    check("p_vld_low", par_bit_vld, 1'b0);

    // 2. Serial even, 07 -> expected parity 1; error held until next start
    do_frame("s_even_ok", 8'h07, 1'b1, T_EVEN, 1'b1, 1'b0);
    do_frame("s_even_bad", 8'h07, 1'b1, T_EVEN, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    check("s_err_held", par_err, 1'b1);
    check("s_done_pulse", chk_done, 1'b0);
    sstart(1'b1, T_EVEN);
    check("s_err_clr", par_err, 1'b0);

    // 3. Serial odd 00 -> expected 1; frame without parity; stray strobe
    do_frame("s_odd", 8'h00, 1'b1, T_ODD, 1'b1, 1'b0);
    do_frame("s_nopar", 8'h5A, 1'b0, T_EVEN, 1'b0, 1'b0);
    sbit(1'b1);
    check("s_stray_done", chk_done, 1'b0);
    check("s_stray_err", par_err, 1'b0);

    // 4. Abort after four strobes, then full frame FF even parity 0
    sstart(1'b1, T_ODD);
    for (int i = 0; i < 4; i++) sbit(1'b1);
    check("s_abort_done", chk_done, 1'b0);
    do_frame("s_ff", 8'hFF, 1'b1, T_EVEN, 1'b0, 1'b0);

    // 5. Mode change mid-frame: latched even mode applies to 01 (parity 1)
    sstart(1'b1, T_EVEN);
    par_typ = T_ODD;
    par_en  = 1'b0;
    for (int i = 0; i < W; i++) sbit(i == 0);
    sbit(1'b1);
    check("s_latch_done", chk_done, 1'b1);
    check("s_latch_err", par_err, 1'b0);

    // Start and strobe in the same cycle: strobe is not counted
    ser_stb = 1'b1; ser_bit = 1'b1;
    sstart(1'b1, T_EVEN);
    ser_stb = 1'b0; ser_bit = 1'b0;
    for (int i = 0; i < W; i++) sbit(1'b0);
    sbit(1'b0);
    check("s_startstb_done", chk_done, 1'b1);
    check("s_startstb_err", par_err, 1'b0);

    // 6. Reset mid-operation: 8-bit in PAR state with par_bit=1,
    //    5-bit holding par_err=1
    frame5("w5_bad", 5'h1F, 1'b0, 1'b1);
    pstrobe(8'hA5, 1'b1, T_ODD);
    sstart(1'b1, T_EVEN);
    for (int i = 0; i < W; i++) sbit(1'b1);
    check("pre_rst_par_bit", par_bit, 1'b1);
    check("pre_rst_err5", par_err5, 1'b1);
    #2 RST = 1'b0;
    #1;
    check("arst_par_bit", par_bit, 1'b0);
    check("arst_vld", par_bit_vld, 1'b0);
    check("arst_done", chk_done, 1'b0);
    check("arst_err", par_err, 1'b0);
    check("arst_err5", par_err5, 1'b0);
    check("arst_done5", chk_done5, 1'b0);
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    sbit(1'b1);
    check("post_rst_idle", chk_done, 1'b0);

    // 5-bit build: 1F has five ones, even parity 1
    frame5("w5_ok", 5'h1F, 1'b1, 1'b0);
    @(negedge CLK);
    check("w5_pulse", chk_done5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
